prog_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 5 +
 rtl/prog_loader_if.sv | 10 +
 rtl/loader_timer.sv | 15 +
 rtl/prog_loader.sv | 105 ++++++++++
 tb/tb_prog_loader.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and frame constants for the program loader
package loader_pkg;
  typedef enum logic [2:0] {IDLE, ADDR_H, ADDR_L, CNT_H, CNT_L, DATA_H, DATA_L, CSUM} state_t;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: received byte stream in, instruction memory write port out
interface prog_loader_if #(parameter int AW = 12, parameter int DW = 16);
  logic [7:0] rx_data;
  logic rx_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic mem_we;
  modport master (output rx_data, rx_valid, input mem_addr, mem_din, mem_we);
  modport slave (input rx_data, rx_valid, output mem_addr, mem_din, mem_we);
endinterface

// File: rtl/loader_timer.sv
// loader_timer: clearable enable-gated counter whose MSB flags an expired wait
module loader_timer #(parameter int W = 20) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic msb
);
  logic [W-1:0] q;
  // clear has priority so an accepted byte always restarts the wait
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) q <= '0;
    else q <= clr ? '0 : en ? q + 1'b1 : q;
  assign msb = q[W-1];
endmodule

// File: rtl/prog_loader.sv
// prog_loader: parses SYNC/addr/count/words/checksum frames into instruction memory writes; define LOADER_TIMEOUT_EN for an inter-byte timeout
module prog_loader
  import loader_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 16,
  parameter logic [7:0] SYNC = SYNC_DEFAULT,
  parameter int TO_BITS = 20
) (
  input  logic clk,
  input  logic rstn,
  prog_loader_if.slave bus,
  output logic cpu_hold,
  output logic [AW-1:0] boot_addr,
  output logic done,
  output logic err
);
  state_t state;
  logic [7:0] sum, hi;
  logic [15:0] cnt, pair;
  logic [AW-1:0] start;
  logic timeout;
  assign pair = {hi, bus.rx_data};
`ifdef LOADER_TIMEOUT_EN
  loader_timer #(.W(TO_BITS)) u_timer (
    .clk(clk),
    .rstn(rstn),
    .clr(bus.rx_valid || state == IDLE),
    .en(state != IDLE),
    .msb(timeout)
  );
`else
  assign timeout = 1'b0;
`endif
  // frame parser; words go to memory as they arrive, checksum only judges the image afterwards
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      sum <= '0;
      hi <= '0;
      cnt <= '0;
      start <= '0;
      bus.mem_addr <= '0;
      bus.mem_din <= '0;
      bus.mem_we <= 1'b0;
      cpu_hold <= 1'b0;
      boot_addr <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      bus.mem_we <= 1'b0;
      if (bus.mem_we) bus.mem_addr <= bus.mem_addr + 1'b1;
      if (timeout && state != IDLE) begin
        state <= IDLE;
        err <= 1'b1;
        cpu_hold <= 1'b0;
      end else if (bus.rx_valid) begin
        if (state != IDLE && state != CSUM) sum <= sum + bus.rx_data;
        case (state)
          IDLE: if (bus.rx_data == SYNC) begin
            state <= ADDR_H;
            sum <= '0;
            cpu_hold <= 1'b1;
            err <= 1'b0;
          end
          ADDR_H: begin
            hi <= bus.rx_data;
            state <= ADDR_L;
          end
          ADDR_L: begin
            start <= pair[AW-1:0];
            bus.mem_addr <= pair[AW-1:0];
            state <= CNT_H;
          end
          CNT_H: begin
            hi <= bus.rx_data;
            state <= CNT_L;
          end
          CNT_L: begin
            cnt <= pair;
            state <= pair == 16'd0 ? CSUM : DATA_H;
          end
          DATA_H: begin
            hi <= bus.rx_data;
            state <= DATA_L;
          end
          DATA_L: begin
            bus.mem_din <= pair;
            bus.mem_we <= 1'b1;
            cnt <= cnt - 1'b1;
            state <= cnt == 16'd1 ? CSUM : DATA_H;
          end
          CSUM: begin
            done <= sum == bus.rx_data;
            err <= sum != bus.rx_data;
            if (sum == bus.rx_data) boot_addr <= start;
            cpu_hold <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed and randomized frames checked against a byte-level frame model
module tb_prog_loader;
  import loader_pkg::*;
  localparam int AW = 12;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  prog_loader_if #(.AW(AW)) bus ();
  logic cpu_hold, done, err;
  logic [AW-1:0] boot_addr;
  prog_loader #(.AW(AW), .TO_BITS(8)) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus),
    .cpu_hold(cpu_hold),
    .boot_addr(boot_addr),
    .done(done),
    .err(err)
  );
  int checks = 0;
  int failures = 0;
  logic [31:0] got_q[$];
  int done_cnt = 0;
  logic [AW-1:0] exp_boot = '0;
  logic [15:0] words[$];
  always @(negedge clk)
    if (rstn) begin
      if (bus.mem_we) got_q.push_back((32'(bus.mem_addr) << 16) | 32'(bus.mem_din));
      if (done) done_cnt++;
    end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask
  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_g(input logic [7:0] b, input int gmax);
    gap($urandom_range(0, gmax));
    send(b);
  endtask
  task automatic run_frame(input string tag, input logic [15:0] a, input bit good, input int gmax);
    logic [7:0] s;
    logic [15:0] c, w;
    logic [31:0] expw[$];
    c = 16'(words.size());
    s = a[15:8] + a[7:0] + c[15:8] + c[7:0];
    got_q.delete();
    done_cnt = 0;
    send(SYNC_DEFAULT);
    check({tag, ":hold_on"}, 32'(cpu_hold), 32'd1);
    check({tag, ":err_clr"}, 32'(err), 32'd0);
    send_g(a[15:8], gmax);
    send_g(a[7:0], gmax);
    send_g(c[15:8], gmax);
    send_g(c[7:0], gmax);
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      s = s + w[15:8] + w[7:0];
      expw.push_back((((32'(a) + 32'(i)) % (32'd1 << AW)) << 16) | 32'(w));
      send_g(w[15:8], gmax);
      send_g(w[7:0], gmax);
    end
    send_g(good ? s : s + 8'd1, gmax);
    check({tag, ":done_pulse"}, 32'(done), 32'(good));
    check({tag, ":hold_off"}, 32'(cpu_hold), 32'd0);
    gap(2);
    if (good) exp_boot = a[AW-1:0];
    check({tag, ":err"}, 32'(err), 32'(!good));
    check({tag, ":done_cnt"}, 32'(done_cnt), 32'(good));
    check({tag, ":boot"}, 32'(boot_addr), 32'(exp_boot));
    check({tag, ":we_cycles"}, 32'(got_q.size()), 32'(expw.size()));
    for (int i = 0; i < expw.size() && i < got_q.size(); i++)
      check({tag, ":write"}, got_q[i], expw[i]);
  endtask
  initial begin
    bus.rx_data = '0;
    bus.rx_valid = 1'b0;
    gap(2);
    check("rst:hold", 32'(cpu_hold), 32'd0);
    check("rst:we", 32'(bus.mem_we), 32'd0);
    check("rst:boot", 32'(boot_addr), 32'd0);
    check("rst:err", 32'(err), 32'd0);
    check("rst:done", 32'(done), 32'd0);
    rstn = 1'b1;
    gap(1);
    send(8'h00);
    send(8'h5A);
    send(8'hFF);
    check("idle_junk:hold", 32'(cpu_hold), 32'd0);
    words = {16'h1234, 16'hABCD};
    run_frame("good", 16'h0800, 1'b1, 0);
    run_frame("badsum", 16'h0800, 1'b0, 0);
    words = {16'h0F0F, 16'hA5A5};
    run_frame("after_bad", 16'h0400, 1'b1, 1);
    words = {};
    run_frame("zero_cnt", 16'h0123, 1'b1, 0);
    words = {16'h1111, 16'h2222};
    run_frame("wrap", 16'h0FFF, 1'b1, 0);
    words = {16'hBEEF};
    run_frame("high_bits", 16'hF345, 1'b1, 2);
    send(SYNC_DEFAULT);
    send(8'h02);
    send(8'h00);
    send(8'h00);
    send(8'h02);
    send(8'h11);
    rstn = 1'b0;
    #1;
    check("midrst:hold", 32'(cpu_hold), 32'd0);
    check("midrst:boot", 32'(boot_addr), 32'd0);
    check("midrst:addr", 32'(bus.mem_addr), 32'd0);
    check("midrst:din", 32'(bus.mem_din), 32'd0);
    check("midrst:we", 32'(bus.mem_we), 32'd0);
    check("midrst:err", 32'(err), 32'd0);
    exp_boot = '0;
    @(negedge clk);
    rstn = 1'b1;
    gap(1);
    words = {16'hCAFE, 16'hF00D, 16'h0001};
    run_frame("post_rst", 16'h0010, 1'b1, 0);
`ifdef LOADER_TIMEOUT_EN
    done_cnt = 0;
    send(SYNC_DEFAULT);
    send(8'h00);
    send(8'h10);
    send(8'h00);
    send(8'h02);
    gap(140);
    check("timeout:err", 32'(err), 32'd1);
    check("timeout:hold", 32'(cpu_hold), 32'd0);
    check("timeout:done", 32'(done_cnt), 32'd0);
    words = {16'h7777};
    run_frame("after_to", 16'h0020, 1'b1, 0);
`endif
    for (int k = 0; k < 8; k++) begin
      words = {};
      for (int j = 0; j < int'($urandom_range(0, 5)); j++) words.push_back(16'($urandom));
      run_frame("rand", 16'($urandom), 1'($urandom_range(0, 3) != 0), 3);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
